// File: rtl/onecold_index_encoder.sv
// onecold_index_encoder
// Recovers the select index from an active-low one-cold line vector.
// The datapath is a two-stage valid/ready pipeline:
//   S1 captures the raw line vector.
//   S2 holds the encoded index and the malformed flag.
// A saturating counter tracks how many malformed vectors passed through S2.
module onecold_index_encoder #(
    parameter int WIDTH   = 32,
    parameter int N_LINES = 8,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   idx_out,
    output logic               err_out,
    output logic [CNT_W-1:0]   err_count
);

    // Wide enough to count every line being zero.
    localparam int ZC_W = $clog2(N_LINES + 1);

    // Pipeline state
    logic               s1_valid_q, s1_valid_d;
    logic [N_LINES-1:0] s1_data_q,  s1_data_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    // Handshake and encoder signals
    logic               s2_load;
    logic               in_fire;
    logic [ZC_W-1:0]    zero_cnt;
    logic [IDX_W-1:0]   zero_pos;
    logic               enc_err;
    logic [IDX_W-1:0]   enc_idx;

    // The upper data bits carry no line information.
    // They are folded into a sink so that they are visibly consumed.
    logic unused_upper;
    if (WIDTH > N_LINES) begin : g_upper
        assign unused_upper = ^data_in[WIDTH-1:N_LINES];
    end else begin : g_no_upper
        assign unused_upper = 1'b0;
    end

    // Handshake: S2 advances when it is empty or being drained.
    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        in_fire  = in_valid && in_ready;
    end

    // Encoder: count the zero lines and remember where the zero sits.
    // The position is only trusted when exactly one line is zero.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        zero_cnt = '0;
        zero_pos = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (!s1_data_q[i]) begin
                zero_cnt = zero_cnt + ZC_W'(1);
                zero_pos = IDX_W'(i);
            end
        end
        enc_err = (zero_cnt != ZC_W'(1));
        enc_idx = enc_err ? '0 : zero_pos;
    end

    // Next-state logic for both pipeline stages and the error counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        err_d       = err_q;
        err_count_d = err_count_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = data_in[N_LINES-1:0];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            // A new result replaces the old one even while it is being drained.
            out_valid_d = 1'b1;
            idx_d       = enc_idx;
            err_d       = enc_err;
            if (enc_err && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and result registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // S1 payload register.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset because s1_valid_q qualifies it. That keeps reset fan-out off the data bits.
        s1_data_q <= s1_data_d;
    end

    assign out_valid = out_valid_q;
    assign idx_out   = idx_q;
    assign err_out   = err_q;
    assign err_count = err_count_q;

endmodule
